// File: rtl/transpose_stream_ctrl_if.sv
// Element-stream bundle for the transpose controller: row-major input and transposed output.
// The master side is the producer/consumer pair; the slave side is the controller.
interface transpose_stream_ctrl_if #(
  parameter int DW = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/transpose_stream_ctrl.sv
// Ping-pong NxN transpose: one bank fills in row-major order while the other drains column-major.
// All handshake outputs are registered from next-state values, so a freed bank is usable at once.
module transpose_stream_ctrl #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  transpose_stream_ctrl_if.slave bus,
  output logic                   busy,
  output logic                   err
);
  localparam int NN   = N * N;
  localparam int IDXW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

  bank_st_e             bank_q [2];
  bank_st_e             bank_d [2];
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [IDXW-1:0]      wr_idx_q, wr_idx_d;
  logic [IDXW-1:0]      rd_idx_q, rd_idx_d;
  logic signed [DW-1:0] mem_q [2][NN];
  logic                 in_ready_q, out_valid_q, out_last_q, busy_q, err_q;
  logic signed [DW-1:0] out_data_q, rd_word_d;
  logic [IDXW-1:0]      rd_addr_d;
  logic                 accept, handshake, err_d, busy_d;

  // Output element k is a[k%N][k/N]; storage is row-major, so address = (k%N)*N + k/N.
  function automatic logic [IDXW-1:0] tr_addr(input logic [IDXW-1:0] idx);
    int unsigned i;
    i = 32'(idx);
    return IDXW'((i % N) * N + i / N);
  endfunction

  always_comb begin
    accept    = bus.in_valid && in_ready_q;
    handshake = out_valid_q && bus.out_ready;
    bank_d    = bank_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;

    if (accept) begin
      if (wr_idx_q == LAST_IDX) begin
        bank_d[wr_bank_q] = FULL;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        bank_d[wr_bank_q] = FILLING;
        wr_idx_d          = wr_idx_q + 1'b1;
      end
    end

    if (handshake) begin
      if (rd_idx_q == LAST_IDX) begin
        bank_d[rd_bank_q] = EMPTY;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        bank_d[rd_bank_q] = DRAINING;
        rd_idx_d          = rd_idx_q + 1'b1;
      end
    end

    rd_addr_d = tr_addr(rd_idx_d);
    // Bypass covers the N=1 case where the element just written is read in the same cycle.
    if (accept && (wr_bank_q == rd_bank_d) && (wr_idx_q == rd_addr_d))
      rd_word_d = bus.in_data;
    else
      rd_word_d = mem_q[rd_bank_d][rd_addr_d];

    err_d  = err_q | (accept && (bus.in_last != (wr_idx_q == LAST_IDX)));
    busy_d = (bank_d[0] != EMPTY) || (bank_d[1] != EMPTY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int e = 0; e < NN; e++)
          mem_q[b][e] <= '0;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      if (accept)
        mem_q[wr_bank_q][wr_idx_q] <= bus.in_data;
      in_ready_q  <= (bank_d[wr_bank_d] == EMPTY) || (bank_d[wr_bank_d] == FILLING);
      out_valid_q <= (bank_d[rd_bank_d] == FULL) || (bank_d[rd_bank_d] == DRAINING);
      out_data_q  <= rd_word_d;
      out_last_q  <= (rd_idx_d == LAST_IDX);
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign err           = err_q;
endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Directed bench for transpose_stream_ctrl: streams hand-built matrices and checks the
// transposed order, handshake timing, back-pressure, framing error and async reset.
module tb_transpose_stream_ctrl;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NN = N * N;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy, err;

  transpose_stream_ctrl_if #(.DW(DW)) bus ();
  transpose_stream_ctrl #(.N(N), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mat [NN];
  logic [DW-1:0] in_q [$];
  logic          last_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] log_q [$];
  int            n_out = 0;
  int            n_acc = 0;
  logic          rdy = 1'b0;
  logic          acc_seen = 1'b0;
  logic          early;
  logic          drop;
  int            base_out, base_acc, base_log, first_c, last_c;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Queue one matrix row-major; in_last marks element last_at; expected output is a[k%N][k/N].
  task automatic push_mat(input int last_at);
    for (int k = 0; k < NN; k++) begin
      in_q.push_back(mat[k]);
      last_q.push_back(k == last_at);
      exp_q.push_back(mat[(k % N) * N + k / N]);
    end
  endtask

  // One clock: drive from the queue, score any handshake, advance to 1 time unit past the edge.
  task automatic tick();
    logic a, h;
    bus.in_valid  = (in_q.size() > 0);
    bus.in_data   = bus.in_valid ? in_q[0] : '0;
    bus.in_last   = bus.in_valid ? last_q[0] : 1'b0;
    bus.out_ready = rdy;
    a = bus.in_valid && bus.in_ready;
    h = bus.out_valid && bus.out_ready;
    if (h) begin
      if (exp_q.size() == 0) begin
        chk("pending_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        chk($sformatf("out_data[%0d]", n_out), bus.out_data, exp_q[0]);
        chk($sformatf("out_last[%0d]", n_out), bus.out_last, (n_out % NN) == NN - 1);
        log_q.push_back(bus.out_data);
        void'(exp_q.pop_front());
        n_out++;
      end
    end
    if (a) begin
      void'(in_q.pop_front());
      void'(last_q.pop_front());
      n_acc++;
    end
    acc_seen = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    #9 reset = 1'b1;
    #1;
    chk("in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_release", bus.in_ready, 1);

    // Test 1: single matrix 0..15
    for (int k = 0; k < NN; k++) mat[k] = DW'(k);
    push_mat(NN - 1);
    rdy   = 1'b1;
    early = 1'b0;
    for (int c = 0; c < 40 && in_q.size() > 0; c++) begin
      if (bus.out_valid) early = 1'b1;
      tick();
    end
    chk("t1_accepts", n_acc, 16);
    chk("t1_no_early_valid", early, 0);
    chk("t1_valid_after_last_accept", bus.out_valid, 1);
    for (int c = 0; c < 40 && n_out < 16; c++) tick();
    chk("t1_outputs", n_out, 16);
    chk("t1_first", log_q[0], 0);
    chk("t1_second", log_q[1], 4);
    chk("t1_fifth", log_q[4], 1);
    chk("t1_last", log_q[15], 15);
    chk("t1_busy_idle", busy, 0);
    chk("t1_out_valid_idle", bus.out_valid, 0);

    // Test 2: three matrices back-to-back at full rate
    base_out = n_out;
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < NN; k++) mat[k] = DW'(200 + 100 * m + k);
      push_mat(NN - 1);
    end
    first_c = -1;
    last_c  = -1;
    drop    = 1'b0;
    for (int c = 0; c < 120 && n_out < base_out + 48; c++) begin
      if (in_q.size() > 0 && !bus.in_ready) drop = 1'b1;
      if (bus.out_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      tick();
    end
    chk("t2_outputs", n_out - base_out, 48);
    chk("t2_in_ready_steady", drop, 0);
    chk("t2_first_out_cycle", first_c, 16);
    chk("t2_contiguous", last_c - first_c + 1, 48);

    // Test 3: downstream stalled, both banks fill
    rdy      = 1'b0;
    base_out = n_out;
    base_acc = n_acc;
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < NN; k++) mat[k] = DW'(500 + 100 * m + k);
      push_mat(NN - 1);
    end
    for (int c = 0; c < 40; c++) tick();
    chk("t3_accepts", n_acc - base_acc, 32);
    chk("t3_in_ready_blocked", bus.in_ready, 0);
    chk("t3_out_valid_held", bus.out_valid, 1);
    chk("t3_out_data_held", bus.out_data, 500);
    chk("t3_out_last_held", bus.out_last, 0);
    rdy = 1'b1;
    for (int c = 0; c < 40 && n_out < base_out + 16; c++) tick();
    chk("t3_mat0_drained", n_out - base_out, 16);
    chk("t3_in_ready_on_free", bus.in_ready, 1);
    for (int c = 0; c < 120 && n_out < base_out + 48; c++) tick();
    chk("t3_all_drained", n_out - base_out, 48);

    // Test 4: signed extremes pass bit-exact
    base_out = n_out;
    for (int k = 0; k < NN; k++) mat[k] = DW'(800 + k);
    mat[1]  = 32'h8000_0000;
    mat[11] = 32'hFFFF_FFFF;
    mat[12] = 32'h7FFF_FFFF;
    push_mat(NN - 1);
    for (int c = 0; c < 80 && n_out < base_out + 16; c++) tick();
    chk("t4_outputs", n_out - base_out, 16);
    chk("t4_out4_min", log_q[base_out + 4], 32'h8000_0000);
    chk("t4_out14_neg1", log_q[base_out + 14], 32'hFFFF_FFFF);
    chk("t4_out3_max", log_q[base_out + 3], 32'h7FFF_FFFF);

    // Test 5: in_last on element 10 instead of 15
    base_out = n_out;
    base_acc = n_acc;
    for (int k = 0; k < NN; k++) mat[k] = DW'(1000 + k);
    push_mat(10);
    for (int c = 0; c < 80 && n_out < base_out + 16; c++) begin
      tick();
      if (acc_seen && n_acc - base_acc == 10) chk("t5_err_before", err, 0);
      if (acc_seen && n_acc - base_acc == 11) chk("t5_err_set", err, 1);
    end
    chk("t5_outputs", n_out - base_out, 16);
    chk("t5_err_sticky", err, 1);

    // Test 6: reset mid-drain, then a fresh matrix
    base_out = n_out;
    for (int k = 0; k < NN; k++) mat[k] = DW'(1100 + k);
    push_mat(NN - 1);
    for (int c = 0; c < 80 && n_out < base_out + 5; c++) tick();
    chk("t6_five_out", n_out - base_out, 5);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_in_ready", bus.in_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err, 0);
    in_q.delete();
    last_q.delete();
    exp_q.delete();
    n_out = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    base_log = log_q.size();
    for (int k = 0; k < NN; k++) mat[k] = DW'(100 + k);
    push_mat(NN - 1);
    for (int c = 0; c < 80 && n_out < 16; c++) tick();
    chk("t6_outputs", n_out, 16);
    chk("t6_first", log_q[base_log], 100);
    chk("t6_second", log_q[base_log + 1], 104);
    chk("t6_last", log_q[base_log + 15], 115);
    chk("t6_busy_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
